// File: rtl/tdm_demux4_pkg.sv
// Shared constants and types for the 4-channel TDM link (transmit and receive sides).
// Both ends rely on the same slot numbering and state encoding.
package tdm_demux4_pkg;

    localparam int unsigned TDM_NCH = 4;
    localparam int unsigned SLOT_W  = 2;

    typedef enum logic {
        StHunt   = 1'b0,
        StLocked = 1'b1
    } tdm_state_e;

    function automatic logic slot_is_last(input logic [SLOT_W-1:0] s);
        return s == SLOT_W'(TDM_NCH - 1);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM link; priority is clear > load > increment.
// Shared with the transmit-side mux sequencer.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [SLOT_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] cnt_o
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM link: stages slots 0-2 and publishes all four channels
// atomically when the slot-3 beat arrives.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned NCH   = TDM_NCH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_sync,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    tdm_state_e        state_q, state_d;
    logic [WIDTH-1:0]  stage_q [NCH-1];
    logic [WIDTH-1:0]  stage_d [NCH-1];
    logic [WIDTH-1:0]  out_q   [NCH];
    logic [WIDTH-1:0]  out_d   [NCH];
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

    logic              ctr_clr;
    logic              ctr_load;
    logic              ctr_inc;
    logic [SLOT_W-1:0] slot_q;

    tdm_slot_ctr u_slot_ctr (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (ctr_clr),
        .load_i     (ctr_load),
        .load_val_i (SLOT_W'(1)),
        .inc_i      (ctr_inc),
        .cnt_o      (slot_q)
    );

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        ctr_clr       = 1'b0;
        ctr_load      = 1'b0;
        ctr_inc       = 1'b0;

        if (in_valid) begin
            case (state_q)
                StHunt: begin
                    if (in_sync) begin
                        stage_d[0] = in_data;
                        ctr_load   = 1'b1;
                        state_d    = StLocked;
                    end
                end
                StLocked: begin
                    if (in_sync) begin
                        // A sync anywhere but slot 0 drops the partial frame and restarts it.
                        sync_err_d = (slot_q != '0);
                        stage_d[0] = in_data;
                        ctr_load   = 1'b1;
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        ctr_clr    = 1'b1;
                        state_d    = StHunt;
                    end else if (slot_is_last(slot_q)) begin
                        for (int i = 0; i < int'(NCH) - 1; i++) begin
                            out_d[i] = stage_q[i];
                        end
                        out_d[NCH-1]  = in_data;
                        frame_valid_d = 1'b1;
                        ctr_clr       = 1'b1;
                    end else begin
                        case (slot_q)
                            SLOT_W'(1): stage_d[1] = in_data;
                            SLOT_W'(2): stage_d[2] = in_data;
                            default:    ;
                        endcase
                        ctr_inc = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < int'(NCH) - 1; i++) begin
                stage_q[i] <= '0;
            end
            for (int i = 0; i < int'(NCH); i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            stage_q       <= stage_d;
            out_q         <= out_d;
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4; completed frames are checked against a scoreboard queue.
module tb_tdm_demux4;

    localparam int unsigned W = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_sync;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;
    logic [4*W-1:0] exp_q [$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sync     (in_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    // Scoreboard monitor: every frame_valid pulse must match the oldest pushed frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            logic [4*W-1:0] e;
            fv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame_unexpected got=%b required=none", {out3, out2, out1, out0});
            end else begin
                e = exp_q.pop_front();
                if ({out3, out2, out1, out0} !== e) begin
                    failures++;
                    $display("FAIL frame_data got=%b required=%b", {out3, out2, out1, out0}, e);
                end
            end
            checks++;
            if (sync_err !== 1'b0) begin
                failures++;
                $display("FAIL fv_and_err got=%b required=0", sync_err);
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the beat's effect visible.
    task automatic beat(input logic s, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sync  = s;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sync = 1'b1; in_data = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out3, out2, out1, out0} !== 4'b0000) begin
            failures++; $display("FAIL reset_outs got=%b required=0000", {out3, out2, out1, out0});
        end
        checks++;
        if ({slot, locked, frame_valid, sync_err} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=00000", {slot, locked, frame_valid, sync_err});
        end
        rst = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        checks++;
        if ({out3, out2, out1, out0} !== 4'b0000 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_no_leak got=%b/%b required=0000/0",
                     {out3, out2, out1, out0}, frame_valid);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
        beat(1'b0, 1'b1);
        checks++;
        if ({frame_valid, slot, locked} !== 4'b1001) begin
            failures++;
            $display("FAIL single_done got=%b required=1001", {frame_valid, slot, locked});
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL single_pulse got=%b required=0", frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fa, fb;
        fa = 4'b0110; fb = 4'b1001;
        for (int f = 0; f < 2; f++) begin
            logic [3:0] fr;
            fr = (f == 0) ? fa : fb;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) exp_q.push_back(mk(fr[0], fr[1], fr[2], fr[3]));
                in_valid = 1'b1; in_sync = (i == 0); in_data = fr[i];
                @(negedge clk);
                checks++;
                if (frame_valid !== (i == 3)) begin
                    failures++;
                    $display("FAIL b2b_fv_f%0d_b%0d got=%b required=%b", f, i, frame_valid, i == 3);
                end
            end
        end
        in_valid = 1'b0; in_sync = 1'b0;
        idle(1);
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        int fv0;
        d = 8'b0010_1111;  // beats 0..7, LSB first
        fv0 = fv_count;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1));
            if (i == 7) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
            beat((i % 4) == 0, d[i]);
            idle(2);
            if (i == 6) begin
                checks++;
                if ({out3, out2, out1, out0} !== 4'b1111) begin
                    failures++;
                    $display("FAIL gaps_hold got=%b required=1111", {out3, out2, out1, out0});
                end
            end
        end
        checks++;
        if (fv_count - fv0 !== 2) begin
            failures++; $display("FAIL gaps_fv_count got=%0d required=2", fv_count - fv0);
        end
    endtask

    task automatic test_valid_gate();
        beat(1'b1, 1'b1);  // slot 0 -> 1
        in_valid = 1'b0; in_sync = 1'b1; in_data = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({slot, locked, sync_err, frame_valid} !== 5'b01100) begin
            failures++;
            $display("FAIL valid_gate got=%b required=01100", {slot, locked, sync_err, frame_valid});
        end
        in_sync = 1'b0;
    endtask

    task automatic test_hunt();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 1'b1);
            checks++;
            if ({sync_err, locked, out3, out2, out1, out0} !== 6'b000000) begin
                failures++;
                $display("FAIL hunt_discard_%0d got=%b required=000000", i,
                         {sync_err, locked, out3, out2, out1, out0});
            end
        end
        beat(1'b1, 1'b0);
        checks++;
        if ({locked, slot} !== 3'b101) begin
            failures++; $display("FAIL hunt_lock got=%b required=101", {locked, slot});
        end
    endtask

    task automatic test_resync();
        beat(1'b0, 1'b0);
        checks++;
        if (slot !== 2'd2) begin
            failures++; $display("FAIL resync_pre got=%0d required=2", slot);
        end
        beat(1'b1, 1'b0);
        checks++;
        if ({sync_err, slot, locked, out3, out2, out1, out0} !== 8'b1011_0000) begin
            failures++;
            $display("FAIL resync_err got=%b required=10110000",
                     {sync_err, slot, locked, out3, out2, out1, out0});
        end
        beat(1'b0, 1'b1);
        checks++;
        if (sync_err !== 1'b0) begin
            failures++; $display("FAIL resync_pulse got=%b required=0", sync_err);
        end
        beat(1'b0, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1));
        beat(1'b0, 1'b1);
        checks++;
        if ({out3, out2, out1, out0} !== 4'b1110) begin
            failures++;
            $display("FAIL resync_frame got=%b required=1110", {out3, out2, out1, out0});
        end
    endtask

    task automatic test_lost_framing();
        beat(1'b0, 1'b1);
        checks++;
        if ({sync_err, locked, slot, out3, out2, out1, out0} !== 8'b1000_1110) begin
            failures++;
            $display("FAIL lost_err got=%b required=10001110",
                     {sync_err, locked, slot, out3, out2, out1, out0});
        end
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        checks++;
        if ({locked, slot} !== 3'b110) begin
            failures++; $display("FAIL lost_relock got=%b required=110", {locked, slot});
        end
        rst = 1'b1; in_valid = 1'b1; in_sync = 1'b0; in_data = '1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out3, out2, out1, out0, slot, locked, frame_valid, sync_err} !== 9'b0) begin
            failures++;
            $display("FAIL midframe_reset got=%b required=000000000",
                     {out3, out2, out1, out0, slot, locked, frame_valid, sync_err});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_valid_gate();
        test_hunt();
        test_resync();
        test_lost_framing();
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
